// File: rtl/sram_ws_bridge.sv
// Bridges one 16 x 48-bit cache line per Wishbone-style request onto three 16-bit async SRAMs.
// Every SRAM pin is registered, so each pin phase appears one cycle after the FSM state that selects it.
module sram_ws_bridge (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  ws_addr,
  input  logic [767:0] ws_din,
  input  logic [95:0]  ws_dm,
  input  logic         ws_stb,
  input  logic         ws_we,
  output logic         ws_ack,
  output logic [767:0] ws_dout,
  output logic [2:0]   sram_ce_n,
  output logic [2:0]   sram_oe_n,
  output logic [2:0]   sram_we_n,
  output logic [2:0]   sram_ub_n,
  output logic [2:0]   sram_lb_n,
  output logic [19:0]  sram_addr,
  inout  wire  [47:0]  sram_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_ACK} state_t;

  state_t       state_reg, state_next;
  logic [1:0]   phase_reg, phase_next;
  logic [3:0]   idx_reg, idx_next;
  logic         start;

  logic [15:0]  line_reg;
  logic [767:0] din_reg;
  logic [95:0]  dm_reg;

  logic [2:0]   ce_reg, oe_reg, we_reg, ub_reg, lb_reg;
  logic [2:0]   ce_next, oe_next, we_next, ub_next, lb_next;
  logic [19:0]  addr_reg, addr_next;
  logic [47:0]  wdata_reg, wdata_next;
  logic         drive_reg, drive_next;
  logic         cap_reg, cap_next;
  logic [3:0]   cap_idx_reg;
  logic         ack_reg, ack_next;

  logic [47:0]  din_word [16];
  logic [5:0]   dm_word [16];
  logic [47:0]  dout_reg [16];
  logic [5:0]   cur_mask;
  logic [2:0]   ub_mask_n, lb_mask_n, chip_sel;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ws_addr[31:22], ws_addr[5:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_word
      assign din_word[gi]         = din_reg[48*gi +: 48];
      assign dm_word[gi]          = dm_reg[6*gi +: 6];
      assign ws_dout[48*gi +: 48] = dout_reg[gi];
    end
  endgenerate

  assign cur_mask = dm_word[idx_reg];

  // Byte j lives on chip j/2: even bytes on the lower strobe, odd on the upper.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chip
      assign lb_mask_n[gi] = ~cur_mask[2*gi];
      assign ub_mask_n[gi] = ~cur_mask[2*gi+1];
      assign chip_sel[gi]  = cur_mask[2*gi] | cur_mask[2*gi+1];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    idx_next   = idx_reg;
    start      = 1'b0;
    ce_next    = 3'b111;
    oe_next    = 3'b111;
    we_next    = 3'b111;
    ub_next    = 3'b111;
    lb_next    = 3'b111;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    drive_next = 1'b0;
    cap_next   = 1'b0;
    ack_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (ws_stb) begin
          start      = 1'b1;
          idx_next   = 4'd0;
          phase_next = 2'd0;
          state_next = ws_we ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        ce_next   = 3'b000;
        oe_next   = 3'b000;
        ub_next   = 3'b000;
        lb_next   = 3'b000;
        addr_next = {line_reg, idx_reg};
        cap_next  = (phase_reg == 2'd2);
      end
      S_WRITE: begin
        ce_next    = 3'b000;
        ub_next    = ub_mask_n;
        lb_next    = lb_mask_n;
        addr_next  = {line_reg, idx_reg};
        wdata_next = din_word[idx_reg];
        drive_next = 1'b1;
        if (phase_reg == 2'd1) begin
          we_next = ~chip_sel;
        end
      end
      S_ACK: begin
        ack_next   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Three phases per word, words ascending; word 15 hands off to the ack cycle.
    if ((state_reg == S_READ) || (state_reg == S_WRITE)) begin
      if (phase_reg == 2'd2) begin
        phase_next = 2'd0;
        idx_next   = idx_reg + 4'd1;
        if (idx_reg == 4'd15) begin
          state_next = S_ACK;
        end
      end else begin
        phase_next = phase_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      phase_reg   <= 2'd0;
      idx_reg     <= 4'd0;
      line_reg    <= 16'd0;
      din_reg     <= '0;
      dm_reg      <= '0;
      ce_reg      <= 3'b111;
      oe_reg      <= 3'b111;
      we_reg      <= 3'b111;
      ub_reg      <= 3'b111;
      lb_reg      <= 3'b111;
      addr_reg    <= 20'd0;
      wdata_reg   <= 48'd0;
      drive_reg   <= 1'b0;
      cap_reg     <= 1'b0;
      cap_idx_reg <= 4'd0;
      ack_reg     <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        dout_reg[k] <= 48'd0;
      end
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      idx_reg     <= idx_next;
      ce_reg      <= ce_next;
      oe_reg      <= oe_next;
      we_reg      <= we_next;
      ub_reg      <= ub_next;
      lb_reg      <= lb_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      drive_reg   <= drive_next;
      cap_reg     <= cap_next;
      cap_idx_reg <= idx_reg;
      ack_reg     <= ack_next;
      if (start) begin
        line_reg <= ws_addr[21:6];
        din_reg  <= ws_din;
        dm_reg   <= ws_dm;
      end
      // The R2 pins were up for the whole cycle now ending, so the data has settled.
      if (cap_reg) begin
        dout_reg[cap_idx_reg] <= sram_data;
      end
    end
  end

  assign ws_ack    = ack_reg;
  assign sram_ce_n = ce_reg;
  assign sram_oe_n = oe_reg;
  assign sram_we_n = we_reg;
  assign sram_ub_n = ub_reg;
  assign sram_lb_n = lb_reg;
  assign sram_addr = addr_reg;
  assign sram_data = drive_reg ? wdata_reg : 48'hz;

endmodule

// File: tb/tb_sram_ws_bridge.sv
// Directed bench for sram_ws_bridge: behavioural byte-strobed SRAM model plus hand-computed lines.
module tb_sram_ws_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  ws_addr = '0;
  logic [767:0] ws_din = '0;
  logic [95:0]  ws_dm = '0;
  logic         ws_stb = 1'b0;
  logic         ws_we = 1'b0;
  logic         ws_ack;
  logic [767:0] ws_dout;
  logic [2:0]   sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [19:0]  sram_addr;
  wire  [47:0]  sram_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ws_bridge dut (
    .clk(clk), .rst(rst), .ws_addr(ws_addr), .ws_din(ws_din), .ws_dm(ws_dm),
    .ws_stb(ws_stb), .ws_we(ws_we), .ws_ack(ws_ack), .ws_dout(ws_dout),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_addr(sram_addr),
    .sram_data(sram_data)
  );

  // SRAM model: drives data while all chips read, stores strobed bytes while we_n is low.
  logic        mdl_drv = 1'b0;
  logic [47:0] mdl_val = '0;
  logic [47:0] mem [int unsigned];
  assign sram_data = mdl_drv ? mdl_val : 48'hz;

  typedef struct {
    logic [19:0] a;
    logic [2:0]  we;
    logic [2:0]  ub;
    logic [2:0]  lb;
    int          c;
  } pulse_t;
  pulse_t pulses[$];

  always @(negedge clk) begin
    logic [47:0] w;
    if (sram_ce_n == 3'b000 && sram_oe_n == 3'b000 && sram_we_n == 3'b111) begin
      mdl_val = mem.exists(sram_addr) ? mem[sram_addr] : 48'h0;
      mdl_drv = 1'b1;
    end else begin
      mdl_drv = 1'b0;
    end
    if (sram_we_n != 3'b111) begin
      pulses.push_back('{a: sram_addr, we: sram_we_n, ub: sram_ub_n, lb: sram_lb_n, c: cyc});
      for (int k = 0; k < 3; k++) begin
        if (!sram_ce_n[k] && !sram_we_n[k]) begin
          w = mem.exists(sram_addr) ? mem[sram_addr] : 48'h0;
          if (!sram_lb_n[k]) w[16*k +: 8] = sram_data[16*k +: 8];
          if (!sram_ub_n[k]) w[16*k+8 +: 8] = sram_data[16*k+8 +: 8];
          mem[sram_addr] = w;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [767:0] line_inc(input logic [47:0] base);
    logic [767:0] l;
    for (int i = 0; i < 16; i++) l[48*i +: 48] = base + 48'(i);
    return l;
  endfunction

  // One request: raise stb, count edges after E0 until ack (bounded), drop stb, confirm one-cycle ack.
  task automatic run_txn(input logic [31:0] a, input logic we, input logic [767:0] din,
                         input logic [95:0] dm, output int lat);
    @(negedge clk);
    ws_addr = a; ws_we = we; ws_din = din; ws_dm = dm; ws_stb = 1'b1;
    @(posedge clk);
    #1;
    e0_cyc = cyc;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (ws_ack) begin
        lat = n;
        break;
      end
    end
    ws_stb = 1'b0;
    @(posedge clk);
    #1;
    check("ack_single_cycle", ws_ack, 1'b0);
    $display("txn addr=%08h we=%0d ack_latency=%0d", a, we, lat);
  endtask

  initial begin
    int lat, np, bad, acks, prev_ack;
    logic [767:0] din, exp_line;
    logic [95:0]  dm;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", ws_ack, 1'b0);
    check("rst_dout", ws_dout, '0);
    check("rst_ce_n", sram_ce_n, 3'b111);
    check("rst_oe_n", sram_oe_n, 3'b111);
    check("rst_we_n", sram_we_n, 3'b111);
    check("rst_ub_n", sram_ub_n, 3'b111);
    check("rst_lb_n", sram_lb_n, 3'b111);
    check("rst_addr", sram_addr, 20'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full write, word i = i, to line 0xFFFF
    np = pulses.size();
    run_txn(32'h003F_FFC0, 1'b1, line_inc(48'h0), {96{1'b1}}, lat);
    check("wr_latency", lat, 49);
    check("wr_pulse_count", pulses.size() - np, 16);
    check("wr_first_addr", pulses[np].a, 20'hFFFF0);
    check("wr_last_addr", pulses[np+15].a, 20'hFFFFF);
    check("wr_first_pulse_cycle", pulses[np].c - e0_cyc, 2);
    bad = 0;
    for (int i = 0; i < 16; i++) if (pulses[np+i].we !== 3'b000) bad++;
    check("wr_we_all_chips", bad, 0);
    check("wr_mem_word5", mem[20'hFFFF5], 48'd5);
    check("wr_dout_unchanged", ws_dout, '0);

    // Read back; din/dm garbage must be ignored
    np = pulses.size();
    run_txn(32'h003F_FFC0, 1'b0, {768{1'b1}}, '0, lat);
    check("rd_latency", lat, 49);
    check("rd_no_we", pulses.size() - np, 0);
    check("rd_line", ws_dout, line_inc(48'h0));

    // Masked write: word0 bytes 0-3, word1 byte 1 only
    din = {768{1'b1}};
    din[47:0]  = 48'hAAAA_BBBB_CCCC;
    din[95:48] = 48'h1111_2222_3344;
    dm = '0;
    dm[5:0]  = 6'b001111;
    dm[11:6] = 6'b000010;
    np = pulses.size();
    run_txn(32'h003F_FFC0, 1'b1, din, dm, lat);
    check("mw_latency", lat, 49);
    check("mw_pulse_count", pulses.size() - np, 2);
    check("mw_p0_addr", pulses[np].a, 20'hFFFF0);
    check("mw_p0_we", pulses[np].we, 3'b100);
    check("mw_p0_ub", pulses[np].ub, 3'b100);
    check("mw_p0_lb", pulses[np].lb, 3'b100);
    check("mw_p1_addr", pulses[np+1].a, 20'hFFFF1);
    check("mw_p1_we", pulses[np+1].we, 3'b110);
    check("mw_p1_ub", pulses[np+1].ub, 3'b110);
    check("mw_p1_lb", pulses[np+1].lb, 3'b111);
    run_txn(32'h003F_FFC0, 1'b0, '0, '0, lat);
    exp_line = line_inc(48'h0);
    exp_line[47:0]  = 48'h0000_BBBB_CCCC;
    exp_line[95:48] = 48'h0000_0000_3301;
    check("mw_readback", ws_dout, exp_line);

    // Back-to-back writes of zeros, stb held, address +64 per ack, wrapping at 0x400000
    np = pulses.size();
    @(negedge clk);
    ws_addr = 32'h003F_FF80; ws_we = 1'b1; ws_din = '0; ws_dm = {96{1'b1}}; ws_stb = 1'b1;
    prev_ack = 0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk);
      lat = -1;
      for (int n = 1; n <= 60; n++) begin
        @(posedge clk);
        #1;
        if (ws_ack) begin
          lat = n;
          break;
        end
      end
      $display("txn b2b#%0d addr=%08h ack_latency=%0d", t, ws_addr, lat);
      check("b2b_latency", lat, 49);
      if (t > 0) check("b2b_ack_spacing", cyc - prev_ack, 50);
      prev_ack = cyc;
      if (t < 2) ws_addr = ws_addr + 32'd64;
      else ws_stb = 1'b0;
    end
    @(posedge clk);
    #1;
    check("b2b_no_extra_ack", ws_ack, 1'b0);
    check("b2b_pulse_count", pulses.size() - np, 48);
    check("b2b_t0_addr", pulses[np].a, 20'hFFFE0);
    check("b2b_t1_addr", pulses[np+16].a, 20'hFFFF0);
    check("b2b_t2_alias_addr", pulses[np+32].a, 20'h00000);
    check("b2b_t2_last_addr", pulses[np+47].a, 20'h0000F);
    check("b2b_mem_cleared", mem[20'hFFFF0], 48'd0);

    // Reset during word 7 of a write to line 1
    np = pulses.size();
    @(negedge clk);
    ws_addr = 32'h0000_0040; ws_we = 1'b1; ws_din = line_inc(48'h5500);
    ws_dm = {96{1'b1}}; ws_stb = 1'b1;
    @(posedge clk);
    repeat (23) @(posedge clk);
    #1;
    check("abort_pre_we", sram_we_n, 3'b000);
    check("abort_pre_addr", sram_addr, 20'h00017);
    rst = 1'b1;
    ws_stb = 1'b0;
    @(posedge clk);
    #1;
    check("abort_we_n", sram_we_n, 3'b111);
    check("abort_ce_n", sram_ce_n, 3'b111);
    check("abort_oe_n", sram_oe_n, 3'b111);
    check("abort_dout", ws_dout, '0);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (ws_ack) acks++;
    end
    check("abort_no_ack", acks, 0);
    check("abort_pulse_count", pulses.size() - np, 8);
    run_txn(32'h0000_0040, 1'b0, '0, '0, lat);
    check("abort_rd_latency", lat, 49);
    exp_line = '0;
    for (int i = 0; i < 8; i++) exp_line[48*i +: 48] = 48'h5500 + 48'(i);
    check("abort_readback", ws_dout, exp_line);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
